// File: rtl/conv3x3_stream.sv
// conv3x3_stream
//   Streaming 3x3 convolution over a raster-order, pre-padded source image of
//   (IMG_W+2) x (IMG_H+2) pixels. Two internal line buffers plus a 3x3 window
//   feed a three-stage multiply / add / shape pipeline that produces an
//   IMG_W x IMG_H result stream.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   start                         begins a frame when idle
//   coef_we, coef_idx, coef_data  kernel tap write (idle only, taps 0..8 raster)
//   shift, abs_en                 result shaping, captured on start
//   s_valid, s_data, s_ready      source pixel stream
//   m_valid, m_data, m_last       result stream (m_last marks final pixel)
//   m_ready                       downstream accept
//   busy                          frame in progress
//   complete                      one-cycle pulse after the final result
module conv3x3_stream #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              coef_we,
  input  logic [3:0]        coef_idx,
  input  logic [COEF_W-1:0] coef_data,
  input  logic [3:0]        shift,
  input  logic              abs_en,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              complete
);

  localparam int SRC_W  = IMG_W + 2;
  localparam int SRC_H  = IMG_H + 2;
  localparam int CW     = $clog2(SRC_W);
  localparam int RW     = $clog2(SRC_H);
  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int SUM_W  = PIX_W + COEF_W + 5;
  localparam int STAGES = 3;
  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             col;
  logic [RW-1:0]             row;
  logic                      in_done;
  logic [3:0]                shift_q;
  logic                      abs_q;
  logic signed [COEF_W-1:0]  coef [0:8];

  logic [PIX_W-1:0]          lb0 [0:SRC_W-1];  // row-1
  logic [PIX_W-1:0]          lb1 [0:SRC_W-1];  // row-2
  logic [PIX_W-1:0]          win [0:2][0:2];   // [row][col], [0][0] = top-left

  logic                      vld_p0, last_p0;
  logic signed [PROD_W-1:0]  prod_p1 [0:8];
  logic                      vld_p1, last_p1;
  logic signed [SUM_W-1:0]   sum_p2;
  logic signed [SUM_W-1:0]   sum_c;
  logic                      vld_p2, last_p2;

  logic en, accept, col_last, row_last, win_ok;

  // Shift (floor), optional magnitude, then clamp into the unsigned pixel range.
  function automatic logic [PIX_W-1:0] shape_pix(input logic signed [SUM_W-1:0] s,
                                                 input logic [3:0] sh,
                                                 input logic ab);
    logic signed [SUM_W-1:0] v;
    v = s >>> sh;
    if (ab && v[SUM_W-1]) v = -v;
    if (v[SUM_W-1])        return '0;
    else if (v >= PIX_MAX) return '1;
    else                   return v[PIX_W-1:0];
  endfunction

  assign en       = !m_valid || m_ready;
  assign s_ready  = (state == S_RUN) && en && !in_done;
  assign accept   = s_valid && s_ready;
  assign col_last = (col == CW'(SRC_W - 1));
  assign row_last = (row == RW'(SRC_H - 1));
  assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    complete  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (m_valid && m_ready && m_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        complete  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame control, raster counters and kernel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      in_done <= 1'b0;
      shift_q <= '0;
      abs_q   <= 1'b0;
      for (int i = 0; i < 9; i++) coef[i] <= (i == 4) ? COEF_W'(1) : '0;
    end else begin
      if (state == S_IDLE && start) begin
        col     <= '0;
        row     <= '0;
        in_done <= 1'b0;
        shift_q <= shift;
        abs_q   <= abs_en;
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row     <= '0;
            in_done <= 1'b1;
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end
      if (state == S_IDLE && coef_we && coef_idx <= 4'd8) coef[coef_idx] <= coef_data;
    end
  end

  // Stage 0: line buffers and window; the new column enters on the right.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= s_data;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[col];
      win[1][2] <= lb0[col];
      win[2][2] <= s_data;
    end
  end

  // Stage 1: nine signed products (pixels zero-extended).
  always_ff @(posedge clk) begin
    if (en) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          prod_p1[r*3+c] <= PROD_W'($signed({1'b0, win[r][c]})) * PROD_W'(coef[r*3+c]);
    end
  end

  // Stage 2: adder tree.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < 9; i++) sum_c = sum_c + SUM_W'(prod_p1[i]);
  end

  always_ff @(posedge clk) begin
    if (en) sum_p2 <= sum_c;
  end

  // Stage 3: shape into the output register; the whole pipe freezes on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (en) begin
      vld_p0  <= accept && win_ok;
      last_p0 <= accept && win_ok && col_last && row_last;
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      m_valid <= vld_p2;
      m_last  <= last_p2;
      if (vld_p2) m_data <= shape_pix(sum_p2, shift_q, abs_q);
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream on a 4x3 output image.
// Expected outputs come from a direct convolution model over the source
// array and are queued at frame start; a monitor pops on each handshake.
module tb_conv3x3_stream;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;
  localparam int SW     = IMG_W + 2;
  localparam int SH     = IMG_H + 2;
  localparam int NSRC   = SW * SH;
  localparam int PMAX   = (1 << PIX_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              coef_we = 1'b0;
  logic [3:0]        coef_idx = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic [3:0]        shift = '0;
  logic              abs_en = 1'b0;
  logic              s_valid = 1'b0;
  logic [PIX_W-1:0]  s_data = '0;
  logic              s_ready;
  logic              m_valid;
  logic [PIX_W-1:0]  m_data;
  logic              m_last;
  logic              m_ready = 1'b1;
  logic              busy;
  logic              complete;

  conv3x3_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .COEF_W(COEF_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .shift(shift), .abs_en(abs_en),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .complete(complete)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   kern [9];
  int   src [NSRC];
  int   exp_d [$];
  bit   exp_l [$];
  bit   mon_en = 1'b1;
  bit   rdy_rand = 1'b0;
  int   first_cyc = -1;
  int   last_cyc = -1;
  int   acc_edge = -1;
  int   n_complete = 0;
  bit   hold_pending = 1'b0;
  int   held_d;
  int   held_l;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare on every handshake, and hold stability on every stall.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else if (mon_en) begin
      if (hold_pending) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, held_d);
        chk("hold_last", m_last, held_l);
        hold_pending = 1'b0;
      end
      if (m_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (m_ready) begin
          if (exp_d.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            chk("out_data", m_data, exp_d.pop_front());
            chk("out_last", m_last, exp_l.pop_front());
          end
          if (m_last) last_cyc = cyc;
        end else begin
          hold_pending = 1'b1;
          held_d = m_data;
          held_l = m_last;
        end
      end
    end
    if (complete) n_complete++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rdy_rand ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int idx, input int val, input bit applies);
    coef_we   = 1'b1;
    coef_idx  = 4'(idx);
    coef_data = COEF_W'(val);
    tick();
    coef_we = 1'b0;
    if (applies && idx <= 8) kern[idx] = val;
  endtask

  task automatic set_kernel(input int k0, input int k1, input int k2, input int k3,
                            input int k4, input int k5, input int k6, input int k7, input int k8);
    int k [9];
    k = '{k0, k1, k2, k3, k4, k5, k6, k7, k8};
    for (int i = 0; i < 9; i++) write_coef(i, k[i], 1'b1);
  endtask

  task automatic make_src(input int pat, input int val);
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        case (pat)
          0:       src[r*SW+c] = 10 * r + c;
          1:       src[r*SW+c] = val;
          2:       src[r*SW+c] = int'($urandom_range(0, PMAX));
          default: src[r*SW+c] = ((r + c) % 2 == 0) ? 0 : PMAX;
        endcase
  endtask

  // Direct definition: output (r,c) is centred on source (r+1,c+1).
  task automatic model_push(input int sh, input bit ab);
    int s, v;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        s = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            s += kern[dr*3+dc] * src[(r+dr)*SW + c + dc];
        v = s >>> sh;
        if (ab && v < 0) v = -v;
        if (v < 0) v = 0;
        else if (v > PMAX) v = PMAX;
        exp_d.push_back(v);
        exp_l.push_back(r == IMG_H - 1 && c == IMG_W - 1);
      end
  endtask

  task automatic start_frame(input int sh, input bit ab);
    shift  = 4'(sh);
    abs_en = ab;
    start  = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("busy_run", busy, 1);
    tick();
  endtask

  task automatic feed(input int n, input bit rnd);
    int g;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = PIX_W'(src[i]);
      g = 0;
      @(negedge clk);
      while (!s_ready && g < 500) begin
        @(negedge clk);
        g++;
      end
      if (!s_ready) begin
        chk("accept_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
      if (i == 2 * SW + 2) acc_edge = cyc + 1;
      tick();
      s_valid = 1'b0;
      if (rnd) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_complete();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!complete && g < 3000);
    chk("complete_seen", complete, 1);
    chk("complete_after_last", cyc, last_cyc + 1);
    chk("queue_drained", exp_d.size(), 0);
    @(negedge clk);
    chk("complete_one_cycle", complete, 0);
    chk("busy_idle", busy, 0);
    tick();
  endtask

  task automatic run_frame(input int sh, input bit ab, input bit rnd);
    model_push(sh, ab);
    start_frame(sh, ab);
    feed(NSRC, rnd);
    wait_complete();
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_complete", complete, 0);
    tick();
  endtask

  initial begin
    int nc;
    for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 1 : 0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs();

    // Identity kernel on a ramp, latency and surplus refusal.
    make_src(0, 0);
    model_push(0, 1'b0);
    first_cyc = -1;
    start_frame(0, 1'b0);
    feed(NSRC, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      chk("no_surplus_accept", s_ready, 0);
    end
    tick();
    s_valid = 1'b0;
    wait_complete();
    chk("first_latency", first_cyc - acc_edge, 3);

    // Box filter with shift, then saturation.
    set_kernel(1, 1, 1, 1, 1, 1, 1, 1, 1);
    make_src(1, 200);
    run_frame(3, 1'b0, 1'b0);
    make_src(1, 255);
    run_frame(3, 1'b0, 1'b0);

    // Sharpen on a checkerboard: negative clamp, then magnitude.
    set_kernel(0, -1, 0, -1, 5, -1, 0, -1, 0);
    make_src(3, 0);
    run_frame(0, 1'b0, 1'b0);
    run_frame(2, 1'b1, 1'b0);

    // Random kernel and data, stall-free then with random backpressure/gaps.
    for (int i = 0; i < 9; i++) write_coef(i, int'($urandom_range(0, 255)) - 128, 1'b1);
    make_src(2, 0);
    run_frame(4, 1'b1, 1'b0);
    rdy_rand = 1'b1;
    run_frame(4, 1'b1, 1'b1);
    make_src(2, 0);
    run_frame(6, 1'b0, 1'b1);
    rdy_rand = 1'b0;

    // Coefficient writes during a frame are ignored; idx > 8 is ignored.
    set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
    write_coef(9, 50, 1'b0);
    make_src(2, 0);
    model_push(0, 1'b0);
    start_frame(0, 1'b0);
    write_coef(4, 7, 1'b0);
    feed(NSRC, 1'b0);
    wait_complete();
    make_src(2, 0);
    run_frame(0, 1'b0, 1'b0);
    write_coef(4, 7, 1'b1);
    make_src(2, 0);
    run_frame(3, 1'b0, 1'b0);

    // Abort mid-frame with reset, then a clean frame on the identity kernel.
    mon_en = 1'b0;
    make_src(0, 0);
    start_frame(0, 1'b0);
    feed(20, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nc = n_complete;
    check_reset_outputs();
    mon_en = 1'b1;
    for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 1 : 0;
    make_src(2, 0);
    run_frame(0, 1'b0, 1'b0);
    tick();
    chk("complete_count_after_abort", n_complete, nc + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
